// File: rtl/alu_multicycle.sv
// alu_multicycle -- WIDTH-generic multi-cycle ALU (AND/OR/ADD/SUB/SLT).
// Operands are consumed SLICE bits per clock, least significant slice first,
// with the slice carry registered between cycles. Result and flags are
// published together once the last slice completes and held until the
// consumer takes them.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready high only while idle)
//   op[2:0]              {sub,s1,s2}: 000 AND, 001 OR, 01x ADD, 110 SUB, 111 SLT
//   a, b, cin            operands and carry-in (effective c0 = cin | op[2])
//   out_valid/out_ready  result handshake
//   f                    result
//   cout, zero, set, ovf registered flags
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             set,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [2:0]         r_op;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_f;
  logic               r_cout;
  logic               r_zero;
  logic               r_set;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic               w_arith;
  logic               w_is_slt;
  logic [SLICE-1:0]   w_a_sl;
  logic [SLICE-1:0]   w_b_raw;
  logic [SLICE-1:0]   w_b_sl;
  logic [SLICE-1:0]   w_logic;
  logic [SLICE:0]     w_sum;
  logic [SLICE-1:0]   w_res;
  logic               w_c_msb;
  logic               w_v;
  logic               w_set;
  logic [WIDTH-1:0]   w_full;
  logic [WIDTH-1:0]   w_final;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_BUSY) && (r_idx == IDX_W'(NSLICE - 1));

  // ---------------- slice datapath ----------------
  // The operand registers shift right one slice per cycle, so the active
  // slice is always the low SLICE bits; no variable indexing is needed.
  assign w_arith  = r_op[1];
  assign w_is_slt = (r_op == 3'b111);
  assign w_a_sl   = r_a[SLICE-1:0];
  assign w_b_raw  = r_b[SLICE-1:0];
  // Inversion of b only matters to the adder; logic ops use b as given.
  assign w_b_sl   = w_b_raw ^ {SLICE{r_op[2]}};
  assign w_logic  = r_op[0] ? (w_a_sl | w_b_raw) : (w_a_sl & w_b_raw);
  assign w_sum    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{SLICE{1'b0}}, r_carry};
  assign w_res    = w_arith ? w_sum[SLICE-1:0] : w_logic;

  // Carry into the slice MSB recovered from the sum bit; on the last slice
  // this is the carry into bit WIDTH-1.
  assign w_c_msb  = w_a_sl[SLICE-1] ^ w_b_sl[SLICE-1] ^ w_sum[SLICE-1];
  assign w_v      = w_c_msb ^ w_sum[SLICE];
  assign w_set    = w_sum[SLICE-1] ^ w_v;

  // Accumulator fills from the top; after NSLICE shifts slice 0 sits at bit 0.
  assign w_full   = (r_acc >> SLICE) | (WIDTH'(w_res) << (WIDTH - SLICE));
  assign w_final  = w_is_slt ? WIDTH'(w_set) : w_full;

  // Working operands and accumulator: no reset, they are only observed
  // through r_f after a complete operation.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
      r_op <= op;
    end else if (r_state == S_BUSY) begin
      r_a   <= r_a >> SLICE;
      r_b   <= r_b >> SLICE;
      r_acc <= w_full;
    end
  end

  // Slice counter, carry chain and published result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_f     <= '0;
      r_cout  <= 1'b0;
      r_zero  <= 1'b0;
      r_set   <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= cin | op[2];
    end else if (r_state == S_BUSY) begin
      r_idx   <= r_idx + IDX_W'(1);
      r_carry <= w_sum[SLICE];
      if (w_last) begin
        r_f    <= w_final;
        r_cout <= w_arith & w_sum[SLICE];
        r_ovf  <= w_arith & w_v;
        r_set  <= w_set;
        r_zero <= (w_final == '0);
      end
    end
  end

  assign f    = r_f;
  assign cout = r_cout;
  assign zero = r_zero;
  assign set  = r_set;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
module tb_alu_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cin, sel;
  logic [2:0]  op;
  logic [31:0] a, b;

  logic        iv0, iv1, or0, or1;
  logic        ir0, ir1, ov0, ov1, co0, co1, z0, z1, s0, s1, v0, v1;
  logic [31:0] f0, f1;

  logic        m_ir, m_ov, m_co, m_z, m_s, m_v;
  logic [31:0] m_f;

  // sel routes the shared stimulus to one instance and its outputs back
  assign iv0 = in_valid & ~sel;
  assign iv1 = in_valid & sel;
  assign or0 = out_ready & ~sel;
  assign or1 = out_ready & sel;
  assign m_ir = sel ? ir1 : ir0;
  assign m_ov = sel ? ov1 : ov0;
  assign m_f  = sel ? f1  : f0;
  assign m_co = sel ? co1 : co0;
  assign m_z  = sel ? z1  : z0;
  assign m_s  = sel ? s1  : s0;
  assign m_v  = sel ? v1  : v0;

  alu_multicycle #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .op(op), .a(a), .b(b),
    .cin(cin), .out_valid(ov0), .out_ready(or0), .f(f0), .cout(co0), .zero(z0),
    .set(s0), .ovf(v0));

  alu_multicycle #(.WIDTH(32), .SLICE(32)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op), .a(a), .b(b),
    .cin(cin), .out_valid(ov1), .out_ready(or1), .f(f1), .cout(co1), .zero(z1),
    .set(s1), .ovf(v1));

  typedef struct packed {
    logic [31:0] f;
    logic        cout;
    logic        zero;
    logic        set;
    logic        ovf;
    logic        care_set;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   npass = 0;

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input logic ci);
    exp_t        r;
    logic [31:0] bb;
    logic [32:0] s;
    logic        c0;
    r  = '0;
    c0 = ci | o[2];
    bb = o[2] ? ~y : y;
    if (o[1]) begin
      s      = {1'b0, x} + {1'b0, bb} + {32'd0, c0};
      r.cout = s[32];
      r.ovf  = (x[31] == bb[31]) && (s[31] != x[31]);
      r.set  = ($signed(x) < $signed(y));
      r.care_set = o[2];
      r.f    = (o == 3'b111) ? {31'd0, r.set} : s[31:0];
    end else begin
      r.f = o[0] ? (x | y) : (x & y);
    end
    r.zero = (r.f == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic ci, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    while (!m_ir && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".in_ready"}, 32'(m_ir), 32'd1);
    op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
    sb.push_back(model(o, x, y, ci));
    @(posedge clk); #1;
    // operands must already be latched; scramble them
    in_valid = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); op = 3'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!m_ov && lat < 20);
    chk({tag, ".latency"}, 32'(lat), sel ? 32'd1 : 32'd4);
    e = sb.pop_front();
    chk({tag, ".f"},    m_f,         e.f);
    chk({tag, ".cout"}, 32'(m_co),   32'(e.cout));
    chk({tag, ".zero"}, 32'(m_z),    32'(e.zero));
    chk({tag, ".ovf"},  32'(m_v),    32'(e.ovf));
    if (e.care_set) chk({tag, ".set"}, 32'(m_s), 32'(e.set));
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = $urandom; b = $urandom; op = 3'($urandom);
      @(posedge clk); #1;
      chk({tag, ".hold_f"},     m_f,         e.f);
      chk({tag, ".hold_cout"},  32'(m_co),   32'(e.cout));
      chk({tag, ".hold_valid"}, 32'(m_ov),   32'd1);
      chk({tag, ".hold_ready"}, 32'(m_ir),   32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".drop_valid"}, 32'(m_ov), 32'd0);
    chk({tag, ".idle_ready"}, 32'(m_ir), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sel = 1'b0;
    op = 3'b000; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state of both instances
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      chk("rst.in_ready",  32'(m_ir), 32'd1);
      chk("rst.out_valid", 32'(m_ov), 32'd0);
      chk("rst.f",         m_f,       32'd0);
      chk("rst.flags",     {28'd0, m_co, m_z, m_s, m_v}, 32'd0);
    end
    sel = 1'b0;

    do_op("add_small",   3'b010, 32'd2,          32'd3,          1'b0, 0);
    do_op("add_carry",   3'b011, 32'h0000_00FF,  32'd1,          1'b0, 0);
    do_op("add_wrap",    3'b010, 32'hFFFF_FFFF,  32'd1,          1'b0, 0);
    do_op("add_cin",     3'b010, 32'h1234_5678,  32'h0FED_CBA8,  1'b1, 0);
    do_op("sub_eq",      3'b110, 32'd3,          32'd3,          1'b0, 0);
    do_op("sub_ovf",     3'b110, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 0);
    do_op("sub_borrow",  3'b110, 32'd1,          32'd2,          1'b0, 0);
    do_op("and",         3'b000, 32'hF0F0_FF00,  32'hFF00_F0F0,  1'b1, 0);
    do_op("or",          3'b001, 32'hF0F0_0000,  32'h0000_0F0F,  1'b0, 0);
    do_op("and_zero",    3'b000, 32'hAAAA_AAAA,  32'h5555_5555,  1'b0, 0);
    do_op("illegal_100", 3'b100, 32'hFFFF_0F0F,  32'h00FF_FF00,  1'b0, 0);
    do_op("illegal_101", 3'b101, 32'h8000_0001,  32'h0000_1000,  1'b0, 0);
    do_op("slt_neg",     3'b111, 32'h8000_0000,  32'd1,          1'b0, 0);
    do_op("slt_false",   3'b111, 32'd5,          32'd4,          1'b0, 0);
    do_op("backpress",   3'b110, 32'h0000_1000,  32'h0000_0001,  1'b0, 5);
    do_op("slt_cin",     3'b111, 32'd2,          32'd7,          1'b1, 0);

    // reset during the second BUSY cycle aborts the op
    op = 3'b010; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.out_valid", 32'(m_ov), 32'd0);
    chk("abort.f",         m_f,       32'd0);
    chk("abort.in_ready",  32'(m_ir), 32'd1);
    chk("abort.flags",     {28'd0, m_co, m_z, m_s, m_v}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort.no_result", 32'(m_ov), 32'd0);
    end

    do_op("post_reset",  3'b010, 32'd100,        32'd23,         1'b0, 0);

    // single-slice instance
    sel = 1'b1;
    #1;
    do_op("w1_add",      3'b010, 32'd10235,      32'd1123,       1'b0, 0);
    do_op("w1_sub_ovf",  3'b110, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 2);
    do_op("w1_slt",      3'b111, 32'hFFFF_FFFE,  32'd3,          1'b0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
